// File: rtl/cdb_arbiter.sv
// Result-broadcast arbiter: ALU and load producers each feed a small FIFO,
// a round-robin pick pops one head per cycle onto a registered CDB.
module cdb_arbiter #(
    parameter int DEPTH     = 2,
    parameter int ROB_IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ROB_IDX_W-1:0] alu_rob_index,
    input  logic [31:0]          alu_res,
    input  logic                 alu_jump,
    input  logic [31:0]          alu_jump_pc,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [ROB_IDX_W-1:0] ld_rob_index,
    input  logic [31:0]          ld_data,
    output logic                 cdb_valid,
    output logic                 cdb_src,
    output logic [ROB_IDX_W-1:0] cdb_rob_index,
    output logic [31:0]          cdb_value,
    output logic                 cdb_jump,
    output logic [31:0]          cdb_jump_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] idx;
        logic [31:0]          res;
        logic                 jump;
        logic [31:0]          jump_pc;
    } alu_ent_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] idx;
        logic [31:0]          data;
    } ld_ent_t;

    alu_ent_t             alu_mem_q [DEPTH];
    alu_ent_t             alu_mem_d [DEPTH];
    logic [PTR_W-1:0]     alu_wp_q, alu_wp_d;
    logic [PTR_W-1:0]     alu_rp_q, alu_rp_d;
    logic [CNT_W-1:0]     alu_cnt_q, alu_cnt_d;

    ld_ent_t              ld_mem_q [DEPTH];
    ld_ent_t              ld_mem_d [DEPTH];
    logic [PTR_W-1:0]     ld_wp_q, ld_wp_d;
    logic [PTR_W-1:0]     ld_rp_q, ld_rp_d;
    logic [CNT_W-1:0]     ld_cnt_q, ld_cnt_d;

    logic                 last_grant_q, last_grant_d;
    logic                 cdb_valid_q, cdb_valid_d;
    logic                 cdb_src_q, cdb_src_d;
    logic [ROB_IDX_W-1:0] cdb_rob_index_q, cdb_rob_index_d;
    logic [31:0]          cdb_value_q, cdb_value_d;
    logic                 cdb_jump_q, cdb_jump_d;
    logic [31:0]          cdb_jump_pc_q, cdb_jump_pc_d;

    logic     alu_push, alu_pop, alu_ne, gnt_alu;
    logic     ld_push, ld_pop, ld_ne, gnt_ld;
    alu_ent_t alu_head;
    ld_ent_t  ld_head;

    assign alu_ready = (alu_cnt_q < CNT_W'(DEPTH));
    assign ld_ready  = (ld_cnt_q < CNT_W'(DEPTH));

    always_comb begin
        alu_ne   = (alu_cnt_q != '0);
        ld_ne    = (ld_cnt_q != '0);
        alu_head = alu_mem_q[alu_rp_q];
        ld_head  = ld_mem_q[ld_rp_q];

        // On a tie the source that did not win last time goes first
        gnt_alu  = alu_ne && (!ld_ne || last_grant_q);
        gnt_ld   = ld_ne && (!alu_ne || !last_grant_q);

        alu_push = alu_valid && alu_ready && rdy;
        ld_push  = ld_valid && ld_ready && rdy;
        alu_pop  = gnt_alu && rdy;
        ld_pop   = gnt_ld && rdy;

        alu_mem_d = alu_mem_q;
        if (alu_push) begin
            alu_mem_d[alu_wp_q] = '{alu_rob_index, alu_res, alu_jump, alu_jump_pc};
        end
        alu_wp_d  = alu_wp_q + PTR_W'(alu_push);
        alu_rp_d  = alu_rp_q + PTR_W'(alu_pop);
        alu_cnt_d = alu_cnt_q + CNT_W'(alu_push) - CNT_W'(alu_pop);

        ld_mem_d = ld_mem_q;
        if (ld_push) begin
            ld_mem_d[ld_wp_q] = '{ld_rob_index, ld_data};
        end
        ld_wp_d  = ld_wp_q + PTR_W'(ld_push);
        ld_rp_d  = ld_rp_q + PTR_W'(ld_pop);
        ld_cnt_d = ld_cnt_q + CNT_W'(ld_push) - CNT_W'(ld_pop);

        last_grant_d    = last_grant_q;
        cdb_valid_d     = cdb_valid_q;
        cdb_src_d       = cdb_src_q;
        cdb_rob_index_d = cdb_rob_index_q;
        cdb_value_d     = cdb_value_q;
        cdb_jump_d      = cdb_jump_q;
        cdb_jump_pc_d   = cdb_jump_pc_q;

        if (rdy) begin
            cdb_valid_d = gnt_alu || gnt_ld;
            if (gnt_alu) begin
                last_grant_d    = 1'b0;
                cdb_src_d       = 1'b0;
                cdb_rob_index_d = alu_head.idx;
                cdb_value_d     = alu_head.res;
                cdb_jump_d      = alu_head.jump;
                cdb_jump_pc_d   = alu_head.jump_pc;
            end else if (gnt_ld) begin
                last_grant_d    = 1'b1;
                cdb_src_d       = 1'b1;
                cdb_rob_index_d = ld_head.idx;
                cdb_value_d     = ld_head.data;
                cdb_jump_d      = 1'b0;
                cdb_jump_pc_d   = '0;
            end
        end
    end

    // Payload storage needs no reset: stale slots are unreachable once pointers clear
    always_ff @(posedge clk) begin
        alu_mem_q <= alu_mem_d;
        ld_mem_q  <= ld_mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            alu_wp_q        <= '0;
            alu_rp_q        <= '0;
            alu_cnt_q       <= '0;
            ld_wp_q         <= '0;
            ld_rp_q         <= '0;
            ld_cnt_q        <= '0;
            last_grant_q    <= 1'b1;
            cdb_valid_q     <= 1'b0;
            cdb_src_q       <= 1'b0;
            cdb_rob_index_q <= '0;
            cdb_value_q     <= '0;
            cdb_jump_q      <= 1'b0;
            cdb_jump_pc_q   <= '0;
        end else begin
            alu_wp_q        <= alu_wp_d;
            alu_rp_q        <= alu_rp_d;
            alu_cnt_q       <= alu_cnt_d;
            ld_wp_q         <= ld_wp_d;
            ld_rp_q         <= ld_rp_d;
            ld_cnt_q        <= ld_cnt_d;
            last_grant_q    <= last_grant_d;
            cdb_valid_q     <= cdb_valid_d;
            cdb_src_q       <= cdb_src_d;
            cdb_rob_index_q <= cdb_rob_index_d;
            cdb_value_q     <= cdb_value_d;
            cdb_jump_q      <= cdb_jump_d;
            cdb_jump_pc_q   <= cdb_jump_pc_d;
        end
    end

    assign cdb_valid     = cdb_valid_q;
    assign cdb_src       = cdb_src_q;
    assign cdb_rob_index = cdb_rob_index_q;
    assign cdb_value     = cdb_value_q;
    assign cdb_jump      = cdb_jump_q;
    assign cdb_jump_pc   = cdb_jump_pc_q;

endmodule
